// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the UART transmitter.
// UART_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

  localparam int CLK_FREQ_DEF = 50_000_000;
  localparam int UART_BPS_DEF = 115200;
  localparam int DATA_BITS    = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_send_baud_gen.sv
// Bit-period counter: counts while enabled, clears on clr or on its own tick,
// and emits a one-cycle tick at count BPS_CNT-1.
module uart_baud_gen #(
  parameter int BPS_CNT = 434
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(BPS_CNT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr || !en || tick) cnt <= '0;
    else                               cnt <= cnt + CW'(1);
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_send.sv
// UART transmitter: 8N1 frames (8E1 when UART_PARITY_EN is defined), LSB first.
// Handshake: a byte is accepted on any rising edge with uart_en=1 and uart_tx_busy=0; uart_en while busy is dropped.
module uart_send
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int UART_BPS = UART_BPS_DEF
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 uart_en,
  input  logic [DATA_BITS-1:0] uart_din,
  output logic                 uart_tx_busy,
  output logic                 uart_tx_done,
  output logic                 uart_txd,
  output uart_state_e          dbg_state
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;

  uart_state_e          state, state_nxt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [2:0]           bit_idx;
  logic                 tick;
  logic                 accept;
`ifdef UART_PARITY_EN
  logic                 parity_bit;
`endif

  assign accept    = uart_en && (state == S_IDLE);
  assign dbg_state = state;

  uart_baud_gen #(.BPS_CNT(BPS_CNT)) u_baud (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (state != S_IDLE),
    .clr     (accept),
    .tick    (tick)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Data path: latch on accept, shift one bit out per DATA bit period.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      shift_reg  <= '0;
      bit_idx    <= '0;
`ifdef UART_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (accept) begin
      shift_reg  <= uart_din;
      bit_idx    <= '0;
`ifdef UART_PARITY_EN
      parity_bit <= ^uart_din;
`endif
    end else if (tick && (state == S_DATA)) begin
      shift_reg  <= shift_reg >> 1;
      bit_idx    <= bit_idx + 3'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_START;
      S_START:  if (tick)   state_nxt = S_DATA;
`ifdef UART_PARITY_EN
      S_DATA:   if (tick && (bit_idx == 3'd7)) state_nxt = S_PARITY;
      S_PARITY: if (tick)   state_nxt = S_STOP;
`else
      S_DATA:   if (tick && (bit_idx == 3'd7)) state_nxt = S_STOP;
`endif
      S_STOP:   if (tick)   state_nxt = S_IDLE;
      default:              state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    uart_txd     = 1'b1;
    uart_tx_busy = 1'b0;
    uart_tx_done = 1'b0;
    case (state)
      S_START: begin
        uart_txd     = 1'b0;
        uart_tx_busy = 1'b1;
      end
      S_DATA: begin
        uart_txd     = shift_reg[0];
        uart_tx_busy = 1'b1;
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        uart_txd     = parity_bit;
        uart_tx_busy = 1'b1;
      end
`endif
      S_STOP: begin
        uart_tx_busy = 1'b1;
        uart_tx_done = tick;
      end
      default: ;
    endcase
  end

endmodule
